plot_arbiter: RTL and testbench
===============================

PLOT_ARBITER -- requirements
Module: plot_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of pixel requesters (fixed 4 in this release).
REQ-002 SHALL have parameter TIMEOUT, default 255, idle cycles allowed before a held grant is revoked.
REQ-003 SHALL have parameter XMAX, default 160, screen width in pixels.
REQ-004 SHALL have parameter YMAX, default 120, screen height in pixels.
REQ-005 SHALL have port CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-006 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req  input  4  requester i wants the VGA write port.
REQ-008 SHALL have port pix_valid  input  4  requester i presents a pixel this cycle.
REQ-009 SHALL have port pix_last  input  4  presented pixel is the final one of requester i's burst.
REQ-010 SHALL have port x_in  input  32  packed x coordinates; requester i uses bits [8i+7:8i].
REQ-011 SHALL have port y_in  input  28  packed y coordinates; requester i uses bits [7i+6:7i].
REQ-012 SHALL have port col_in  input  12  packed colours; requester i uses bits [3i+2:3i].
REQ-013 SHALL have port grant  output  4  registered one-hot grant; all zero when no owner.
REQ-014 SHALL have port plot  output  1  registered write strobe to vga_adapter.
REQ-015 SHALL have port x_out  output  8  registered x to vga_adapter.
REQ-016 SHALL have port y_out  output  7  registered y to vga_adapter.
REQ-017 SHALL have port colour_out  output  3  registered colour to vga_adapter.
REQ-018 SHALL have port drop_count  output  8  saturating count of off-screen pixels discarded.
REQ-019 SHALL have port busy  output  1  high whenever grant is non-zero.

Function
REQ-020 SHALL implement states IDLE, OWN, GAP.
REQ-021 IDLE: if any req bit high, SHALL select winner by round-robin starting at (last_owner+1) mod 4, set grant one-hot, enter OWN on the next edge.
REQ-022 IDLE with req=0 SHALL hold grant=0, plot=0.
REQ-023 OWN: a pixel is accepted in any cycle where grant[g] and pix_valid[g]; pix_valid of non-owners SHALL be ignored.
REQ-024 Accepted on-screen pixel (x<XMAX and y<YMAX) SHALL appear on x_out/y_out/colour_out with plot=1 exactly one cycle after acceptance.
REQ-025 Accepted off-screen pixel SHALL leave plot=0 and increment drop_count, saturating at 255.
REQ-026 plot SHALL be 0 in every cycle not immediately following an accepted on-screen pixel; x_out/y_out/colour_out SHALL hold their last values otherwise.
REQ-027 OWN SHALL exit to GAP on: accepted pixel with pix_last[g]; req[g] low; or idle counter reaching TIMEOUT.
REQ-028 Idle counter (8-bit) SHALL clear on entering OWN and on every accepted pixel, increment each OWN cycle without acceptance.
REQ-029 req[g] low in the same cycle as an accepted pixel: pixel SHALL still be plotted, then exit to GAP.
REQ-030 GAP SHALL last exactly one cycle with grant=0, record last_owner=g, then return to IDLE.
REQ-031 Minimum handover: last pixel of owner A to grant of owner B SHALL be 3 cycles (OWN->GAP->IDLE->OWN).
REQ-032 req changes of non-owners during OWN SHALL not affect the current grant.
REQ-033 busy SHALL equal OR of grant bits.

Reset
REQ-034 resetn low SHALL immediately force state IDLE, grant=0, plot=0, x_out=0, y_out=0, colour_out=0, drop_count=0, idle counter=0, last_owner=3 (so requester 0 wins first).
REQ-035 Reset asserted mid-burst SHALL discard any pending pixel; after release arbitration restarts from requester 0.

Verification
REQ-036 Reset, then req=4'b0101 held -> grant=0001 one cycle later; after requester 0 sends 3 pixels ending pix_last, grant=0100 three cycles after last pixel.
REQ-037 Owner 1 presents (x=10,y=20,col=3'b110) -> next cycle plot=1, x_out=10, y_out=20, colour_out=6; following cycle plot=0.
REQ-038 Owner presents x=160,y=5 then x=3,y=120 -> plot stays 0, drop_count=2; 300 off-screen pixels -> drop_count=255.
REQ-039 Owner 2 holds req, no pix_valid for 255 cycles -> grant drops to 0 (GAP), next waiting requester granted round-robin.
REQ-040 Owner 3 drops req in same cycle as valid pixel -> pixel plotted next cycle, grant=0 same cycle; all four req high -> grant order 0,1,2,3,0.
REQ-041 resetn pulsed low during owner 1 burst -> grant, plot, drop_count zero asynchronously; after release with req=1111 grant=0001.

Source files
------------

// File: rtl/plot_arbiter_if.sv
// Requester-side pixel bus and vga_adapter-side write port shared by plot_arbiter.
// Four requesters pack their coordinates side by side, requester i in slot i.
interface plot_arbiter_if;
  logic [3:0]  req;
  logic [3:0]  pix_valid;
  logic [3:0]  pix_last;
  logic [31:0] x_in;
  logic [27:0] y_in;
  logic [11:0] col_in;
  logic [3:0]  grant;
  logic        plot;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour_out;
  logic [7:0]  drop_count;
  logic        busy;

  modport master (
    output req, pix_valid, pix_last, x_in, y_in, col_in,
    input  grant, plot, x_out, y_out, colour_out, drop_count, busy
  );

  modport slave (
    input  req, pix_valid, pix_last, x_in, y_in, col_in,
    output grant, plot, x_out, y_out, colour_out, drop_count, busy
  );
endinterface

// File: rtl/plot_arbiter.sv
// Round-robin arbiter sharing the single vga_adapter write port among four pixel requesters.
// Off-screen pixels are discarded and counted instead of being plotted.
//
// state | meaning
// IDLE  | no owner; pick the next requester round-robin after last_owner
// OWN   | owner holds the port; its pixels are accepted and forwarded
// GAP   | one dead cycle after release; last_owner is updated
module plot_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255,
  parameter int XMAX    = 160,
  parameter int YMAX    = 120
) (
  input  logic CLOCK_50,
  input  logic resetn,
  plot_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  localparam logic [8:0] XLIM   = XMAX[8:0];
  localparam logic [7:0] YLIM   = YMAX[7:0];
  localparam logic [7:0] TO_CNT = TIMEOUT[7:0];

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [3:0] grant_q, grant_d;
  logic [7:0] idle_q, idle_d;

  logic       plot_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] col_q;
  logic [7:0] drop_q;

  logic [1:0] win, rr_idx;
  logic       win_found;

  logic [4:0] y_base;
  logic [3:0] c_base;
  logic [7:0] cur_x;
  logic [6:0] cur_y;
  logic [2:0] cur_c;
  logic       accept, on_screen;

  assign y_base    = 5'(owner_q) * 5'd7;
  assign c_base    = 4'(owner_q) * 4'd3;
  assign cur_x     = bus.x_in[{owner_q, 3'b000} +: 8];
  assign cur_y     = bus.y_in[y_base +: 7];
  assign cur_c     = bus.col_in[c_base +: 3];
  assign accept    = (state_q == OWN) && bus.pix_valid[owner_q];
  assign on_screen = ({1'b0, cur_x} < XLIM) && ({1'b0, cur_y} < YLIM);

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    win       = last_q;
    win_found = 1'b0;
    rr_idx    = last_q;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = last_q + 2'(k);
      if (!win_found && bus.req[rr_idx]) begin
        win       = rr_idx;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    idle_d  = idle_q;
    case (state_q)
      IDLE: begin
        grant_d = 4'b0000;
        if (win_found) begin
          owner_d = win;
          grant_d = 4'b0001 << win;
          idle_d  = 8'd0;
          state_d = OWN;
        end
      end
      OWN: begin
        idle_d = accept ? 8'd0 : idle_q + 8'd1;
        // A final pixel is still forwarded even when req drops with it.
        if ((accept && bus.pix_last[owner_q]) || !bus.req[owner_q] ||
            (!accept && idle_q == TO_CNT)) begin
          grant_d = 4'b0000;
          state_d = GAP;
        end
      end
      GAP: begin
        grant_d = 4'b0000;
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: begin
        grant_d = 4'b0000;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      grant_q <= 4'b0000;
      idle_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      idle_q  <= idle_d;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      plot_q <= 1'b0;
      x_q    <= 8'd0;
      y_q    <= 7'd0;
      col_q  <= 3'd0;
      drop_q <= 8'd0;
    end else begin
      plot_q <= accept && on_screen;
      if (accept && on_screen) begin
        x_q   <= cur_x;
        y_q   <= cur_y;
        col_q <= cur_c;
      end
      if (accept && !on_screen && drop_q != 8'hFF) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  assign bus.grant      = grant_q;
  assign bus.busy       = |grant_q;
  assign bus.plot       = plot_q;
  assign bus.x_out      = x_q;
  assign bus.y_out      = y_q;
  assign bus.colour_out = col_q;
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter: a vector table for arbitration and pixel forwarding,
// then hand-written sequences for round-robin order, timeout, drop saturation and reset.
module tb_plot_arbiter;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  int   n_cmp    = 0;
  int   n_bad    = 0;

  plot_arbiter_if bus ();

  plot_arbiter #(.NREQ(4), .TIMEOUT(255), .XMAX(160), .YMAX(120)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [3:0] req;
    logic [3:0] vld;
    logic [3:0] lst;
    int         who;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic [3:0] e_grant;
    logic       e_plot;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_c;
    logic [7:0] e_drop;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic [3:0] req, logic [3:0] vld, logic [3:0] lst, int who,
                              logic [7:0] x, logic [6:0] y, logic [2:0] c,
                              logic [3:0] eg, logic ep, logic [7:0] ex, logic [6:0] ey,
                              logic [2:0] ec, logic [7:0] ed);
    vec_t v;
    v.req = req; v.vld = vld; v.lst = lst; v.who = who;
    v.x = x; v.y = y; v.c = c;
    v.e_grant = eg; v.e_plot = ep; v.e_x = ex; v.e_y = ey; v.e_c = ec; v.e_drop = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic drive_all(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    bus.x_in   = {4{x}};
    bus.y_in   = {4{y}};
    bus.col_in = {4{c}};
  endtask

  task automatic wait_grant(input logic [3:0] exp, input string name);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.grant != 4'b0000) break;
    end
    chk(name, 32'(bus.grant), 32'(exp));
  endtask

  initial begin
    // Owner 0 burst, handover to 2, drops/boundaries, handover to 1, req drop with pixel.
    vecs[0]  = mk(4'b0101, 4'b0000, 4'b0000, 0,   0,   0, 0, 4'b0001, 0,   0,   0, 0, 0);
    vecs[1]  = mk(4'b0101, 4'b0001, 4'b0000, 0,   1,   2, 3, 4'b0001, 1,   1,   2, 3, 0);
    vecs[2]  = mk(4'b0101, 4'b0001, 4'b0000, 0,   4,   5, 1, 4'b0001, 1,   4,   5, 1, 0);
    vecs[3]  = mk(4'b0101, 4'b0001, 4'b0001, 0,   7,   8, 2, 4'b0000, 1,   7,   8, 2, 0);
    vecs[4]  = mk(4'b0101, 4'b0000, 4'b0000, 0,   0,   0, 0, 4'b0000, 0,   7,   8, 2, 0);
    vecs[5]  = mk(4'b0101, 4'b0000, 4'b0000, 0,   0,   0, 0, 4'b0100, 0,   7,   8, 2, 0);
    vecs[6]  = mk(4'b0101, 4'b0001, 4'b0001, 0,   9,   9, 5, 4'b0100, 0,   7,   8, 2, 0);
    vecs[7]  = mk(4'b0101, 4'b0100, 4'b0000, 2, 160,   5, 1, 4'b0100, 0,   7,   8, 2, 1);
    vecs[8]  = mk(4'b0101, 4'b0100, 4'b0000, 2,   3, 120, 1, 4'b0100, 0,   7,   8, 2, 2);
    vecs[9]  = mk(4'b0111, 4'b0100, 4'b0000, 2, 159, 119, 7, 4'b0100, 1, 159, 119, 7, 2);
    vecs[10] = mk(4'b0001, 4'b0000, 4'b0000, 0,   0,   0, 0, 4'b0000, 0, 159, 119, 7, 2);
    vecs[11] = mk(4'b0010, 4'b0000, 4'b0000, 0,   0,   0, 0, 4'b0000, 0, 159, 119, 7, 2);
    vecs[12] = mk(4'b0010, 4'b0000, 4'b0000, 0,   0,   0, 0, 4'b0010, 0, 159, 119, 7, 2);
    vecs[13] = mk(4'b0010, 4'b0010, 4'b0000, 1,  10,  20, 6, 4'b0010, 1,  10,  20, 6, 2);
    vecs[14] = mk(4'b0010, 4'b0000, 4'b0000, 0,   0,   0, 0, 4'b0010, 0,  10,  20, 6, 2);
    vecs[15] = mk(4'b0000, 4'b0010, 4'b0000, 1,  11,  21, 5, 4'b0000, 1,  11,  21, 5, 2);

    bus.req = 4'b0000; bus.pix_valid = 4'b0000; bus.pix_last = 4'b0000;
    drive_all(8'd0, 7'd0, 3'd0);

    #12;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_plot",  32'(bus.plot),  32'd0);
    chk("rst_xyc",   {bus.x_out, 1'b0, bus.y_out, 5'd0, bus.colour_out}, 32'd0);
    chk("rst_drop",  32'(bus.drop_count), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    @(negedge CLOCK_50);
    resetn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      bus.req       = vecs[i].req;
      bus.pix_valid = vecs[i].vld;
      bus.pix_last  = vecs[i].lst;
      bus.x_in      = 32'(vecs[i].x) << (8 * vecs[i].who);
      bus.y_in      = 28'(vecs[i].y) << (7 * vecs[i].who);
      bus.col_in    = 12'(vecs[i].c) << (3 * vecs[i].who);
      tick();
      chk($sformatf("v%0d_grant", i), 32'(bus.grant), 32'(vecs[i].e_grant));
      chk($sformatf("v%0d_busy", i),  32'(bus.busy),  32'(|vecs[i].e_grant));
      chk($sformatf("v%0d_plot", i),  32'(bus.plot),  32'(vecs[i].e_plot));
      chk($sformatf("v%0d_x", i),     32'(bus.x_out), 32'(vecs[i].e_x));
      chk($sformatf("v%0d_y", i),     32'(bus.y_out), 32'(vecs[i].e_y));
      chk($sformatf("v%0d_col", i),   32'(bus.colour_out), 32'(vecs[i].e_c));
      chk($sformatf("v%0d_drop", i),  32'(bus.drop_count), 32'(vecs[i].e_drop));
    end

    // Owner 3 drops req together with a valid pixel.
    bus.req = 4'b1000; bus.pix_valid = 4'b0000; bus.pix_last = 4'b0000;
    tick();
    tick();
    chk("own3_grant", 32'(bus.grant), 32'b1000);
    bus.req = 4'b0000; bus.pix_valid = 4'b1000;
    drive_all(8'd50, 7'd60, 3'd4);
    tick();
    chk("own3_plot",  32'(bus.plot), 32'd1);
    chk("own3_xyc",   {bus.x_out, 1'b0, bus.y_out, 5'd0, bus.colour_out}, {8'd50, 1'b0, 7'd60, 5'd0, 3'd4});
    chk("own3_grant0", 32'(bus.grant), 32'd0);
    bus.pix_valid = 4'b0000;

    // All four requesting: ownership rotates 0,1,2,3,0.
    bus.req = 4'b1111;
    drive_all(8'd20, 7'd30, 3'd1);
    for (int n = 0; n < 5; n++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (n % 4);
      wait_grant(exp_g, $sformatf("rr%0d_grant", n));
      bus.pix_valid = bus.grant;
      bus.pix_last  = 4'b1111;
      tick();
      chk($sformatf("rr%0d_plot", n), 32'(bus.plot), 32'd1);
      bus.pix_valid = 4'b0000;
      bus.pix_last  = 4'b0000;
    end

    // Owner 2 idles until the timeout revokes its grant.
    bus.req = 4'b0100;
    wait_grant(4'b0100, "to_grant");
    bus.req = 4'b0101;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (i == 100) bus.req = 4'b0111;
    end
    chk("to_hold", 32'(bus.grant), 32'b0100);
    tick();
    chk("to_drop", 32'(bus.grant), 32'd0);
    tick();
    tick();
    chk("to_next", 32'(bus.grant), 32'b0001);

    // Off-screen pixels from owner 0 saturate drop_count.
    bus.req = 4'b0101; bus.pix_valid = 4'b0001;
    drive_all(8'd200, 7'd0, 3'd2);
    for (int i = 0; i < 252; i++) tick();
    chk("sat_254", 32'(bus.drop_count), 32'd254);
    for (int i = 0; i < 48; i++) tick();
    chk("sat_255", 32'(bus.drop_count), 32'd255);
    chk("sat_plot", 32'(bus.plot), 32'd0);
    chk("sat_grant", 32'(bus.grant), 32'b0001);

    // Reset pulse in the middle of an owner 1 burst.
    bus.pix_valid = 4'b0000; bus.req = 4'b0010;
    wait_grant(4'b0010, "rb_grant");
    bus.pix_valid = 4'b0010;
    drive_all(8'd10, 7'd20, 3'd3);
    tick();
    chk("rb_plot", 32'(bus.plot), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_grant", 32'(bus.grant), 32'd0);
    chk("ar_plot",  32'(bus.plot),  32'd0);
    chk("ar_drop",  32'(bus.drop_count), 32'd0);
    chk("ar_x",     32'(bus.x_out), 32'd0);
    chk("ar_busy",  32'(bus.busy), 32'd0);
    bus.req = 4'b1111; bus.pix_valid = 4'b0000;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    tick();
    chk("ar_restart", 32'(bus.grant), 32'b0001);
    chk("ar_noplot",  32'(bus.plot), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
